// File: rtl/ikbd_serial.sv
// ikbd_serial: device-side 8N1 UART, the keyboard-controller end of the ACIA link.
//   Received bytes are deserialised and presented as a one-cycle strobe.
//   Outgoing bytes are queued in a small FIFO and shifted back to the ACIA.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tx_data, tx_strobe  one-cycle write of a byte into the TX FIFO
//   tx_full             FIFO holds 2**FIFO_AW bytes
//   tx_busy             FIFO non-empty or a frame is being shifted out
//   tx_overflow         pulse: write dropped because the FIFO was full
//   rx_data, rx_strobe  last good received byte, pulse when it updates
//   rx_frame_error      pulse: stop bit sampled low
//   serial_out          line to ACIA rx (idles high)
//   serial_in           line from ACIA tx
module ikbd_serial #(
    parameter int CLK_DIV = 256,
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_strobe,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       rx_frame_error,
    output logic       serial_out,
    input  logic       serial_in
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // ---------------- oversample tick ----------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    assign tick = (tick_cnt_q == TW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt_q <= '0;
        else               tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;
    logic               push, pop, fifo_ne;

    assign tx_full     = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign fifo_ne     = (count_q != '0);
    assign push        = tx_strobe && !tx_full;  // judged on pre-cycle count
    assign tx_overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= tx_strobe && tx_full;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_sub_q, tx_sub_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_out_q, tx_out_d;

    assign serial_out = tx_out_q;
    assign tx_busy    = fifo_ne || (tx_state_q != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_sub_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sub_q   <= tx_sub_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_out_q   <= tx_out_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sub_d   = tx_sub_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_out_d   = tx_out_q;
        pop        = 1'b0;
        if (tick) begin
            // every non-idle bit lasts 16 ticks; sub-count 15 marks the boundary
            tx_sub_d = (tx_state_q == TX_IDLE) ? 4'd0 : tx_sub_q + 4'd1;
            unique case (tx_state_q)
                TX_IDLE: if (fifo_ne) begin
                    pop        = 1'b1;
                    tx_sh_d    = mem_q[rd_ptr_q];
                    tx_out_d   = 1'b0;
                    tx_state_d = TX_START;
                end
                TX_START: if (tx_sub_q == 4'd15) begin
                    tx_bit_d   = '0;
                    tx_out_d   = tx_sh_q[0];
                    tx_state_d = TX_DATA;
                end
                TX_DATA: if (tx_sub_q == 4'd15) begin
                    tx_sh_d = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_out_d   = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_out_d = tx_sh_q[1];
                    end
                end
                TX_STOP: if (tx_sub_q == 4'd15) begin
                    // chain straight into the next start bit when more is queued
                    if (fifo_ne) begin
                        pop        = 1'b1;
                        tx_sh_d    = mem_q[rd_ptr_q];
                        tx_out_d   = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    // ---------------- RX conditioning ----------------
    logic [1:0] sync_q;
    logic [3:0] samp_q;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            samp_q <= 4'b1111;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            samp_q <= {samp_q[2:0], sync_q[1]};
            // hysteresis: only a unanimous window changes the filtered level
            if (samp_q == 4'b0000)      filt_q <= 1'b0;
            else if (samp_q == 4'b1111) filt_q <= 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_sub_q, rx_sub_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_stb_q, rx_stb_d;
    logic       rx_ferr_q, rx_ferr_d;

    assign rx_data        = rx_data_q;
    assign rx_strobe      = rx_stb_q;
    assign rx_frame_error = rx_ferr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_sub_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_stb_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sub_q   <= rx_sub_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_stb_q   <= rx_stb_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sub_d   = rx_sub_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_stb_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        if (tick) begin
            rx_sub_d = rx_sub_q + 4'd1;
            unique case (rx_state_q)
                RX_IDLE: if (!filt_q) begin
                    rx_sub_d   = '0;
                    rx_state_d = RX_START;
                end
                RX_START: if (rx_sub_q == 4'd7) begin
                    // mid start bit: a line already back high was a false start
                    rx_sub_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = filt_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_sub_q == 4'd15) begin
                    rx_sh_d = {filt_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
                RX_STOP: if (rx_sub_q == 4'd15) begin
                    if (filt_q) begin
                        rx_data_d  = rx_sh_q;
                        rx_stb_d   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end
                RX_BREAK: if (filt_q) rx_state_d = RX_IDLE;
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ikbd_serial.sv
module tb_ikbd_serial;
    localparam int CDIV  = 8;
    localparam int BIT   = 16 * CDIV;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0, reset = 1'b1, tx_strobe = 1'b0, serial_in = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_full, tx_busy, tx_overflow, rx_strobe, rx_frame_error, serial_out;
    logic [7:0] rx_data;

    ikbd_serial #(.CLK_DIV(CDIV), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_strobe(tx_strobe),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_overflow(tx_overflow),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_frame_error(rx_frame_error),
        .serial_out(serial_out), .serial_in(serial_in));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cycle count and expected tick phase (counter restarts at reset)
    int cyc = 0, ph = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) ph <= 0;
        else       ph <= (ph == CDIV - 1) ? 0 : ph + 1;
    end

    // serial_out frame decoder: samples mid-bit from the detected start edge
    int         mon_cnt = -1, mon_start = 0, tx_frame_bad = 0;
    logic [9:0] mon_bits = '0;
    logic [7:0] tx_got[$];
    int         tx_got_start[$];
    always @(negedge clk) begin
        if (reset) mon_cnt <= -1;
        else if (mon_cnt < 0) begin
            if (serial_out === 1'b0) begin mon_cnt <= 1; mon_start <= cyc; end
        end else if (mon_cnt == 9 * BIT + BIT / 2) begin
            tx_got.push_back(mon_bits[8:1]);
            tx_got_start.push_back(mon_start);
            if (mon_bits[0] !== 1'b0 || serial_out !== 1'b1) tx_frame_bad <= tx_frame_bad + 1;
            mon_cnt <= -1;
        end else begin
            if (mon_cnt % BIT == BIT / 2) mon_bits[mon_cnt / BIT] <= serial_out;
            mon_cnt <= mon_cnt + 1;
        end
    end

    // event logging
    int         edges[$];
    logic       so_prev = 1'b1, busy_prev = 1'b0;
    int         n_ferr = 0, n_ovf = 0, busy_fall = -1, last_rx_cyc = 0;
    logic [7:0] rx_got[$];
    always @(negedge clk) begin
        if (serial_out !== so_prev) edges.push_back(cyc);
        so_prev <= serial_out;
        if (rx_strobe === 1'b1) begin rx_got.push_back(rx_data); last_rx_cyc <= cyc; end
        if (rx_frame_error === 1'b1) n_ferr <= n_ferr + 1;
        if (tx_overflow === 1'b1) n_ovf <= n_ovf + 1;
        if (busy_prev === 1'b1 && tx_busy === 1'b0) busy_fall <= cyc;
        busy_prev <= tx_busy;
    end

    logic [7:0] tx_exp[$];
    logic       rx_abort = 1'b0;

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(logic [7:0] b);
        tx_data = b; tx_strobe = 1'b1;
        @(negedge clk);
        tx_strobe = 1'b0;
        tx_exp.push_back(b);
    endtask

    task automatic send_rx(logic [7:0] b, logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            for (int j = 0; j < BIT; j++) begin
                if (rx_abort) begin serial_in = 1'b1; return; end
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_tx_idle(string tag, int budget);
        for (int i = 0; i < budget && tx_busy !== 1'b0; i++) @(negedge clk);
        wait_clk(2);
        check(tag, tx_busy, 1'b0);
    endtask

    // compare decoded frames with the written order; optionally require no gaps
    task automatic compare_tx(string tag, bit b2b);
        check({tag, "_count"}, tx_got.size(), tx_exp.size());
        for (int k = 0; k < tx_exp.size() && k < tx_got.size(); k++) begin
            check({tag, "_byte"}, tx_got[k], tx_exp[k]);
            if (b2b && k > 0) check({tag, "_gap"}, tx_got_start[k] - tx_got_start[k-1], FRAME);
        end
        tx_got.delete(); tx_got_start.delete(); tx_exp.delete();
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t_w, d, ovf0, ferr0, t0, nexp;
        int         exp_edge[$];
        logic [9:0] lvl;
        logic [7:0] r, prev_rx;

        // ---- reset state ----
        wait_clk(3);
        check("rst_serial_out", serial_out, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_tx_overflow", tx_overflow, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_strobe", rx_strobe, 1'b0);
        check("rst_rx_ferr", rx_frame_error, 1'b0);
        reset = 1'b0;

        // ---- idle ----
        wait_clk(10000);
        check("idle_serial_out", serial_out, 1'b1);
        check("idle_tx_busy", tx_busy, 1'b0);
        check("idle_events", rx_got.size() + tx_got.size() + n_ferr + n_ovf, 0);

        // ---- single frame A5, edge timing ----
        edges.delete();
        t_w = cyc;
        write_byte(8'hA5);
        wait_tx_idle("a5_idle", FRAME + 4 * CDIV);
        lvl = {1'b1, 8'hA5, 1'b0};
        exp_edge.push_back(0);
        for (int i = 1; i < 10; i++) if (lvl[i] != lvl[i-1]) exp_edge.push_back(i * BIT);
        check("a5_edge_count", edges.size(), exp_edge.size());
        if (edges.size() > 0) begin
            d = edges[0] - t_w;
            check("a5_start_latency_ok", (d >= 1 && d <= CDIV + 1), 1'b1);
            for (int k = 1; k < exp_edge.size() && k < edges.size(); k++)
                check("a5_edge_time", edges[k] - edges[0], exp_edge[k]);
            check("a5_busy_fall", busy_fall - edges[0], FRAME);
        end
        compare_tx("a5", 1'b0);

        // ---- random bytes written at random times ----
        for (int i = 0; i < 3; i++) begin
            write_byte(8'($urandom));
            wait_clk($urandom_range(1, FRAME));
        end
        wait_tx_idle("rnd_idle", 4 * FRAME);
        compare_tx("rnd", 1'b0);

        // ---- burst of 9 straddling a tick: all accepted ----
        for (int i = 0; i < CDIV && ph != CDIV - 4; i++) @(negedge clk);
        ovf0 = n_ovf;
        for (int i = 1; i <= 9; i++) begin
            tx_data = 8'(i); tx_strobe = 1'b1; tx_exp.push_back(8'(i));
            @(negedge clk);
        end
        tx_strobe = 1'b0;
        wait_clk(2);
        check("burst_no_overflow", n_ovf - ovf0, 0);
        wait_tx_idle("burst_idle", 10 * FRAME);
        compare_tx("burst", 1'b1);

        // ---- overflow: 8 queued behind an active frame, 9th dropped ----
        write_byte(8'($urandom));
        for (int i = 0; i < CDIV + 4 && serial_out !== 1'b0; i++) @(negedge clk);
        wait_clk(2);
        ovf0 = n_ovf;
        for (int i = 0; i < 9; i++) begin
            r = 8'($urandom);
            tx_data = r; tx_strobe = 1'b1;
            if (i < 8) tx_exp.push_back(r);
            @(negedge clk);
        end
        tx_strobe = 1'b0;
        check("ovf_full", tx_full, 1'b1);
        wait_clk(2);
        check("ovf_pulses", n_ovf - ovf0, 1);
        wait_tx_idle("ovf_idle", 11 * FRAME);
        compare_tx("ovf", 1'b1);

        // ---- RX 0x80 and latency ----
        t0 = cyc;
        send_rx(8'h80, 1'b1);
        wait_clk(BIT);
        check("rx80_count", rx_got.size(), 1);
        check("rx80_data", rx_data, 8'h80);
        d = last_rx_cyc - t0;
        check("rx80_latency_ok", (d >= 19 * BIT / 2 && d <= 19 * BIT / 2 + CDIV + 10), 1'b1);

        // ---- 3-clock glitch ignored ----
        serial_in = 1'b0; wait_clk(3); serial_in = 1'b1;
        wait_clk(2 * FRAME);
        check("glitch_no_strobe", rx_got.size(), 1);
        check("glitch_no_ferr", n_ferr, 0);
        rx_got.delete();

        // ---- random RX bytes ----
        for (int i = 0; i < 2; i++) begin
            r = 8'($urandom);
            send_rx(r, 1'b1);
            wait_clk(BIT);
            check("rxrnd_count", rx_got.size(), 1);
            if (rx_got.size() > 0) check("rxrnd_data", rx_got[0], r);
            rx_got.delete();
            prev_rx = r;
        end

        // ---- framing error then held-low break ----
        ferr0 = n_ferr;
        send_rx(8'h3C, 1'b0);
        wait_clk(3 * FRAME);
        check("brk_ferr_once", n_ferr - ferr0, 1);
        check("brk_no_strobe", rx_got.size(), 0);
        check("brk_rx_data_held", rx_data, prev_rx);
        serial_in = 1'b1;
        wait_clk(2 * BIT);
        send_rx(8'h12, 1'b1);
        wait_clk(BIT);
        check("brk_after_count", rx_got.size(), 1);
        check("brk_after_data", rx_data, 8'h12);
        check("brk_ferr_total", n_ferr - ferr0, 1);
        rx_got.delete();

        // ---- reset mid-frame on both directions ----
        ferr0 = n_ferr;
        write_byte(8'hFF);
        tx_exp.delete();
        fork
            send_rx(8'h5A, 1'b1);
            begin
                wait_clk(4 * BIT + $urandom_range(0, BIT));
                reset = 1'b1; rx_abort = 1'b1; serial_in = 1'b1;
                @(negedge clk);
                check("mid_rst_serial_out", serial_out, 1'b1);
                check("mid_rst_tx_busy", tx_busy, 1'b0);
                check("mid_rst_tx_full", tx_full, 1'b0);
                reset = 1'b0;
            end
        join
        rx_abort = 1'b0;
        wait_clk(3 * FRAME);
        check("mid_rst_no_rx", rx_got.size(), 0);
        check("mid_rst_no_ferr", n_ferr - ferr0, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_no_tx_frame", tx_got.size(), 0);
        tx_got.delete(); tx_got_start.delete();
        write_byte(8'($urandom));
        wait_tx_idle("post_rst_idle", 2 * FRAME);
        compare_tx("post_rst", 1'b0);

        check("tx_framing_all", tx_frame_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
